// File: rtl/run_controller_if.sv
// Run-control bus between the test harness (master) and run_controller (slave).
// Carries the start/done handshake, the run status and the active program base.
interface run_controller_if #(
  parameter int PC_W  = 32,
  parameter int CNT_W = 16
);
  logic             start;
  logic             done_in;
  logic             run_en;
  logic             core_clr;
  logic [PC_W-1:0]  pc_base;
  logic [1:0]       prog_idx;
  logic             ack;
  logic             timeout;
  logic [CNT_W-1:0] cycle_count;

  modport master (
    output start, done_in,
    input  run_en, core_clr, pc_base, prog_idx, ack, timeout, cycle_count
  );

  modport slave (
    input  start, done_in,
    output run_en, core_clr, pc_base, prog_idx, ack, timeout, cycle_count
  );
endinterface

// File: rtl/run_controller.sv
// Run-control sequencer for the 9-bit single-cycle core.
// One run per start pulse: clear the core, hold while start is high, enable
// fetch/execute until done or the cycle limit, then raise ack. Also tracks
// which resident program is active and supplies its base PC.
module run_controller #(
  parameter int MAX_CYCLES  = 4096,
  parameter int CNT_W       = 16,
  parameter int NUM_PROGS   = 3,
  parameter int PROG_STRIDE = 256,
  parameter int PC_W        = 32
) (
  input logic            clk,
  input logic            reset,
  run_controller_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    HOLD,
    RUN,
    FINISH
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LIMIT_M1 = CNT_W'(MAX_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT    = CNT_W'(MAX_CYCLES);
  localparam logic [1:0]       LAST_IDX     = 2'(NUM_PROGS - 1);
  localparam logic [PC_W-1:0]  STRIDE       = PC_W'(PROG_STRIDE);

  state_t           r_state;
  logic             r_run_en;
  logic             r_core_clr;
  logic             r_ack;
  logic             r_timeout;
  logic [CNT_W-1:0] r_cycle_count;
  logic [1:0]       r_prog_idx;
  logic [PC_W-1:0]  r_pc_base;

  logic [1:0]       w_next_idx;
  logic [PC_W-1:0]  w_next_pc;
  logic [CNT_W-1:0] w_count_inc;

  // Next program index (wrapping) and its base address, used on FINISH->CLEAR.
  always_comb begin
    w_next_idx  = (r_prog_idx == LAST_IDX) ? 2'd0 : r_prog_idx + 2'd1;
    w_next_pc   = PC_W'(w_next_idx) * STRIDE;
    w_count_inc = r_cycle_count + CNT_W'(1);
  end

  // Run sequencer: state and every output are registered together so no
  // input reaches an output combinationally.
  // NOTE: non-blocking assignments so every register sees pre-edge values;
  // the async reset branch clears all state, aborting a run with no partial ack.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= IDLE;
      r_run_en      <= 1'b0;
      r_core_clr    <= 1'b0;
      r_ack         <= 1'b0;
      r_timeout     <= 1'b0;
      r_cycle_count <= '0;
      r_prog_idx    <= 2'd0;
      r_pc_base     <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_state       <= CLEAR;
            r_core_clr    <= 1'b1;
            r_ack         <= 1'b0;
            r_timeout     <= 1'b0;
            r_cycle_count <= '0;
          end
        end

        CLEAR: begin
          r_state    <= HOLD;
          r_core_clr <= 1'b0;
        end

        HOLD: begin
          if (!bus.start) begin
            r_state  <= RUN;
            r_run_en <= 1'b1;
          end
        end

        RUN: begin
          if (bus.done_in) begin
            // Done wins over the limit; the completing cycle is counted.
            r_state       <= FINISH;
            r_run_en      <= 1'b0;
            r_ack         <= 1'b1;
            r_timeout     <= 1'b0;
            r_cycle_count <= w_count_inc;
          end else if (r_cycle_count == CNT_LIMIT_M1) begin
            r_state       <= FINISH;
            r_run_en      <= 1'b0;
            r_ack         <= 1'b1;
            r_timeout     <= 1'b1;
            r_cycle_count <= CNT_LIMIT;
          end else begin
            r_cycle_count <= w_count_inc;
          end
        end

        FINISH: begin
          if (bus.start) begin
            r_state       <= CLEAR;
            r_core_clr    <= 1'b1;
            r_ack         <= 1'b0;
            r_timeout     <= 1'b0;
            r_cycle_count <= '0;
            r_prog_idx    <= w_next_idx;
            r_pc_base     <= w_next_pc;
          end
        end

        // NOTE: unreachable encodings recover to IDLE rather than locking up.
        default: begin
          r_state    <= IDLE;
          r_run_en   <= 1'b0;
          r_core_clr <= 1'b0;
        end
      endcase
    end
  end

  assign bus.run_en      = r_run_en;
  assign bus.core_clr    = r_core_clr;
  assign bus.ack         = r_ack;
  assign bus.timeout     = r_timeout;
  assign bus.cycle_count = r_cycle_count;
  assign bus.prog_idx    = r_prog_idx;
  assign bus.pc_base     = r_pc_base;

endmodule

// File: tb/tb_run_controller.sv
// Self-checking bench for run_controller: stimulus pushes the expected outcome
// of each run into a queue; a negedge monitor pops and compares on ack rise.
module tb_run_controller;

  localparam int MAX_CYCLES  = 16;
  localparam int CNT_W       = 16;
  localparam int NUM_PROGS   = 3;
  localparam int PROG_STRIDE = 256;
  localparam int PC_W        = 32;

  logic clk = 1'b0;
  logic reset;

  run_controller_if #(.PC_W(PC_W), .CNT_W(CNT_W)) bus ();

  run_controller #(
    .MAX_CYCLES (MAX_CYCLES),
    .CNT_W      (CNT_W),
    .NUM_PROGS  (NUM_PROGS),
    .PROG_STRIDE(PROG_STRIDE),
    .PC_W       (PC_W)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned idx;
    int unsigned pc;
    int unsigned tmo;
    int unsigned cnt;
    int unsigned run_cycles;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   run_num  = 0;   // completed-or-started runs since the last reset

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: a run with done on RUN cycle d ends after d cycles,
  // otherwise the limit ends it after MAX_CYCLES with timeout set.
  // The n-th run since reset uses program n mod NUM_PROGS.
  task automatic do_run(input int hold, input int done_at, input bit noise);
    int last;
    int tmo;
    int idx;
    if (done_at >= 1 && done_at <= MAX_CYCLES) begin
      last = done_at; tmo = 0;
    end else begin
      last = MAX_CYCLES; tmo = 1;
    end
    idx = run_num % NUM_PROGS;
    exp_q.push_back('{idx: idx, pc: idx * PROG_STRIDE, tmo: tmo, cnt: last, run_cycles: last});
    run_num++;
    bus.start = 1'b1;
    for (int i = 0; i < hold; i++) begin
      bus.done_in = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      @(posedge clk); #1;
    end
    bus.start   = 1'b0;
    bus.done_in = 1'b0;
    @(posedge clk); #1;
    for (int k = 1; k <= last; k++) begin
      bus.done_in = (k == done_at);
      bus.start   = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      @(posedge clk); #1;
    end
    bus.start   = 1'b0;
    bus.done_in = noise ? 1'($urandom_range(0, 1)) : 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    bus.done_in = 1'b0;
    check("ack_seen_for_run", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_run_en"},   bus.run_en,      0);
    check({tag, "_core_clr"}, bus.core_clr,    0);
    check({tag, "_ack"},      bus.ack,         0);
    check({tag, "_timeout"},  bus.timeout,     0);
    check({tag, "_count"},    bus.cycle_count, 0);
    check({tag, "_prog_idx"}, bus.prog_idx,    0);
    check({tag, "_pc_base"},  bus.pc_base,     0);
  endtask

  // Monitor: counts core_clr and run_en cycles per run and compares on ack rise.
  initial begin : monitor
    int   en_cycles;
    int   clr_cycles;
    logic prev_ack;
    exp_t e;
    en_cycles = 0; clr_cycles = 0; prev_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        en_cycles = 0; clr_cycles = 0; prev_ack = 1'b0;
      end else begin
        if (bus.core_clr) begin
          clr_cycles++;
          en_cycles = 0;
          check("clear_ack_low",    bus.ack,         0);
          check("clear_count_zero", bus.cycle_count, 0);
        end
        if (bus.run_en) en_cycles++;
        if (bus.ack && !prev_ack) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_ack: got ack with no run pending, expected none");
          end else begin
            e = exp_q.pop_front();
            check("prog_idx",      bus.prog_idx,    64'(e.idx));
            check("pc_base",       bus.pc_base,     64'(e.pc));
            check("timeout",       bus.timeout,     64'(e.tmo));
            check("cycle_count",   bus.cycle_count, 64'(e.cnt));
            check("run_en_cycles", 64'(en_cycles),  64'(e.run_cycles));
            check("clr_pulse_len", 64'(clr_cycles), 64'd1);
            check("run_en_low_at_ack", bus.run_en,  0);
          end
          clr_cycles = 0;
        end
        prev_ack = bus.ack;
      end
    end
  end

  initial begin : watchdog
    #50000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    reset       = 1'b1;
    bus.start   = 1'b0;
    bus.done_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_values("in_reset");
    reset = 1'b0;
    @(posedge clk); #1;
    check_reset_values("after_reset");

    // Directed: basic, timeout, simultaneous done+limit, wrap to program 0.
    do_run(3, 10, 1'b0);
    do_run(2, 0, 1'b0);
    do_run(2, MAX_CYCLES, 1'b0);
    do_run(2, int'($urandom_range(1, MAX_CYCLES)), 1'b0);

    // Randomized runs with ignored-input noise (done in HOLD, start in RUN).
    for (int r = 0; r < 8; r++)
      do_run(int'($urandom_range(2, 5)), int'($urandom_range(0, MAX_CYCLES + 4)), 1'b1);

    // Async reset in the middle of a run.
    bus.start = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    bus.start = 1'b0;
    @(posedge clk); #1;
    repeat (4) @(posedge clk);
    #1;
    check("abort_in_run", bus.run_en, 1);
    #2 reset = 1'b1;
    #1;
    check_reset_values("async_abort");
    run_num = 0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    check("no_ack_after_abort", bus.ack, 0);

    do_run(3, 5, 1'b0);
    do_run(2, 7, 1'b0);

    check("pending_at_end", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
